// File: rtl/text_entry_ctrl.sv
// Custom-text entry controller: PS/2 scan codes into a fixed-length buffer,
// then a req/ack commit of the frozen buffer to the letter converter.
module text_entry_ctrl #(
    parameter int         TEXT_LEN_MAX = 20,
    parameter logic [7:0] FILL_CODE    = 8'h29
) (
    input  logic                      clock_27mhz,
    input  logic                      reset,
    input  logic                      edit_en,
    input  logic                      button_enter,
    input  logic [7:0]                scan_code,
    input  logic                      scan_rdy,
    input  logic                      commit_ack,
    output logic [TEXT_LEN_MAX*8-1:0] char_array,
    output logic [5:0]                char_len,
    output logic                      accepting,
    output logic                      commit_req,
    output logic                      text_valid,
    output logic                      overflow,
    output logic [1:0]                state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTRY  = 2'd1,
        COMMIT = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [5:0] LEN_MAX    = 6'(TEXT_LEN_MAX);
    localparam logic [7:0] CODE_BKSP  = 8'h66;
    localparam logic [7:0] CODE_ENTER = 8'h5A;

    state_t     cur_state;
    state_t     nxt_state;
    logic [7:0] slot [TEXT_LEN_MAX];
    logic [5:0] len_q;
    logic       do_clear;
    logic       do_write;
    logic       do_back;
    logic       drop;

    function automatic logic printable(input logic [7:0] c);
        case (c)
            8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
            8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
            8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
            8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A, 8'h29:
                printable = 1'b1;
            default:
                printable = 1'b0;
        endcase
    endfunction

    always_comb begin
        nxt_state = cur_state;
        do_clear  = 1'b0;
        do_write  = 1'b0;
        do_back   = 1'b0;
        drop      = 1'b0;
        case (cur_state)
            IDLE: begin
                if (edit_en) begin
                    nxt_state = ENTRY;
                    do_clear  = 1'b1;
                end
            end
            ENTRY: begin
                // abort outranks any key or enter seen in the same cycle
                if (!edit_en) begin
                    nxt_state = IDLE;
                    do_clear  = 1'b1;
                end else begin
                    if (scan_rdy) begin
                        if (printable(scan_code)) begin
                            if (len_q < LEN_MAX) do_write = 1'b1;
                            else                 drop     = 1'b1;
                        end else if (scan_code == CODE_BKSP) begin
                            do_back = (len_q != 6'd0);
                        end else if (scan_code == CODE_ENTER) begin
                            nxt_state = COMMIT;
                        end
                    end
                    if (button_enter) nxt_state = COMMIT;
                end
            end
            COMMIT: begin
                if (commit_ack) nxt_state = DONE;
            end
            DONE: begin
                if (!edit_en) nxt_state = IDLE;
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clock_27mhz or negedge reset) begin
        if (!reset) begin
            cur_state  <= IDLE;
            accepting  <= 1'b0;
            commit_req <= 1'b0;
            text_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            cur_state  <= nxt_state;
            accepting  <= (nxt_state == ENTRY);
            commit_req <= (nxt_state == COMMIT);
            text_valid <= (nxt_state == DONE);
            overflow   <= drop;
        end
    end

    always_ff @(posedge clock_27mhz or negedge reset) begin
        if (!reset) begin
            len_q <= 6'd0;
            for (int k = 0; k < TEXT_LEN_MAX; k++) slot[k] <= FILL_CODE;
        end else if (do_clear) begin
            len_q <= 6'd0;
            for (int k = 0; k < TEXT_LEN_MAX; k++) slot[k] <= FILL_CODE;
        end else if (do_write) begin
            len_q <= len_q + 6'd1;
            for (int k = 0; k < TEXT_LEN_MAX; k++)
                if (len_q == 6'(k)) slot[k] <= scan_code;
        end else if (do_back) begin
            len_q <= len_q - 6'd1;
            for (int k = 0; k < TEXT_LEN_MAX; k++)
                if (len_q == 6'(k + 1)) slot[k] <= FILL_CODE;
        end
    end

    for (genvar k = 0; k < TEXT_LEN_MAX; k++) begin : g_pack
        assign char_array[8*(TEXT_LEN_MAX-1-k) +: 8] = slot[k];
    end

    assign char_len = len_q;
    assign state    = cur_state;

endmodule

// File: tb/tb_text_entry_ctrl.sv
// Directed + randomized bench for text_entry_ctrl against a queue-based
// model of the entry/commit rules.
module tb_text_entry_ctrl;

    localparam int TL = 20;
    localparam int W  = TL * 8;
    localparam logic [7:0] PR [27] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
        8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
        8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
        8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A, 8'h29
    };

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         edit_en = 1'b0;
    logic         button_enter = 1'b0;
    logic [7:0]   scan_code = 8'h00;
    logic         scan_rdy = 1'b0;
    logic         commit_ack = 1'b0;
    logic [W-1:0] char_array;
    logic [5:0]   char_len;
    logic         accepting;
    logic         commit_req;
    logic         text_valid;
    logic         overflow;
    logic [1:0]   state;

    int checks = 0;
    int errors = 0;

    // model: 0 idle, 1 entry, 2 commit, 3 done
    int         m_mode = 0;
    logic [7:0] m_q [$];
    logic       m_ovf = 1'b0;

    text_entry_ctrl #(.TEXT_LEN_MAX(TL), .FILL_CODE(8'h29)) dut (
        .clock_27mhz (clk),
        .reset       (reset),
        .edit_en     (edit_en),
        .button_enter(button_enter),
        .scan_code   (scan_code),
        .scan_rdy    (scan_rdy),
        .commit_ack  (commit_ack),
        .char_array  (char_array),
        .char_len    (char_len),
        .accepting   (accepting),
        .commit_req  (commit_req),
        .text_valid  (text_valid),
        .overflow    (overflow),
        .state       (state)
    );

    always #5 clk = ~clk;

    function automatic bit is_pr(input logic [7:0] c);
        for (int i = 0; i < 27; i++) if (PR[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_q.delete();
        m_ovf = 1'b0;
    endtask

    task automatic model_clk(input logic en, be, rdy,
                             input logic [7:0] code, input logic ack);
        bit go;
        go = 0;
        m_ovf = 1'b0;
        case (m_mode)
            0: if (en) begin m_q.delete(); m_mode = 1; end
            1: begin
                if (!en) begin
                    m_q.delete();
                    m_mode = 0;
                end else begin
                    if (rdy) begin
                        if (is_pr(code)) begin
                            if (m_q.size() < TL) m_q.push_back(code);
                            else m_ovf = 1'b1;
                        end else if (code == 8'h66) begin
                            if (m_q.size() > 0) void'(m_q.pop_back());
                        end else if (code == 8'h5A) go = 1;
                    end
                    if (be) go = 1;
                    if (go) m_mode = 2;
                end
            end
            2: if (ack) m_mode = 3;
            default: if (!en) m_mode = 0;
        endcase
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [W-1:0] ea;
        ea = '0;
        for (int k = 0; k < TL; k++)
            ea[8*(TL-1-k) +: 8] = (k < m_q.size()) ? m_q[k] : 8'h29;
        chk("state", W'(state), W'(m_mode));
        chk("char_len", W'(char_len), W'(m_q.size()));
        chk("char_array", char_array, ea);
        chk("accepting", W'(accepting), W'(m_mode == 1));
        chk("commit_req", W'(commit_req), W'(m_mode == 2));
        chk("text_valid", W'(text_valid), W'(m_mode == 3));
        chk("overflow", W'(overflow), W'(m_ovf));
    endtask

    task automatic step(input logic en, be, rdy,
                        input logic [7:0] code, input logic ack);
        edit_en      = en;
        button_enter = be;
        scan_rdy     = rdy;
        scan_code    = code;
        commit_ack   = ack;
        @(posedge clk);
        model_clk(en, be, rdy, code, ack);
        #1;
        check_all();
        button_enter = 1'b0;
        scan_rdy     = 1'b0;
        commit_ack   = 1'b0;
    endtask

    task automatic key(input logic [7:0] c);
        step(1'b1, 1'b0, 1'b1, c, 1'b0);
    endtask

    task automatic idle(input logic en);
        step(en, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        logic [7:0] hello [5];
        logic [7:0] c;
        int r;
        hello = '{8'h33, 8'h24, 8'h4B, 8'h4B, 8'h44};

        #2 reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1 check_all();
        #2 reset = 1'b1;
        @(posedge clk);
        #1 check_all();

        // HELLO, enter, late ack, leave with buffer retained
        idle(1'b1);
        foreach (hello[i]) key(hello[i]);
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        idle(1'b1);
        idle(1'b1);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        key(8'h1C);
        idle(1'b0);
        idle(1'b0);

        // backspace and underflow
        idle(1'b1);
        key(8'h1C); key(8'h32); key(8'h66); key(8'h21);
        key(8'h66); key(8'h66); key(8'h66);
        key(8'hF0); key(8'hE0);

        // fill and overflow
        for (int i = 0; i < TL + 1; i++) key(PR[$urandom_range(0, 26)]);
        key(8'h1A);
        idle(1'b1);

        // abort with len 4
        idle(1'b0);
        idle(1'b1);
        key(8'h1C); key(8'h32); key(8'h21); key(8'h23);
        idle(1'b0);

        // same-cycle key + button_enter at len 3
        idle(1'b1);
        key(8'h1C); key(8'h32); key(8'h21);
        step(1'b1, 1'b1, 1'b1, 8'h2C, 1'b0);
        step(1'b1, 1'b1, 1'b1, 8'h35, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        idle(1'b0);

        // enter scan code alone; edit_en drop in COMMIT does not abort
        idle(1'b1);
        key(8'h44);
        key(8'h5A);
        idle(1'b0);
        idle(1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        idle(1'b0);
        idle(1'b0);

        // ack outside COMMIT and same-cycle abort priority
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        idle(1'b1);
        step(1'b0, 1'b1, 1'b1, 8'h1C, 1'b0);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 9);
            if (r < 6)      c = PR[$urandom_range(0, 26)];
            else if (r < 8) c = 8'h66;
            else if (r < 9) c = 8'h5A;
            else            c = 8'($urandom());
            step(($urandom_range(0, 19) != 0),
                 ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 1) == 1), c,
                 ($urandom_range(0, 4) == 0));
        end

        // async reset between edges while in COMMIT
        idle(1'b0);
        idle(1'b1);
        key(8'h2C); key(8'h24);
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        #2 reset = 1'b0;
        model_reset();
        #1 check_all();
        @(posedge clk);
        #1 check_all();
        #2 reset = 1'b1;
        idle(1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/text_entry_ctrl.md
Name: text_entry_ctrl

Overview:
- Sequences custom-text entry during the ADD_EDITS phase.
- Consumes PS/2 scan-code strobes and maintains a fixed-length character buffer with cursor, backspace and overflow handling.
- On enter, hands the frozen buffer to the scan-code-to-letter converter through a req/ack commit handshake.
- Sits between the PS/2 keyboard decoder and the letter converter; the top-level FSM gates it with edit_en.

Parameters:
- TEXT_LEN_MAX, 20: buffer capacity in characters. Legal range 1..63.
- FILL_CODE, 8'h29: scan code used for empty slots (space).

Ports:
- clock_27mhz  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- edit_en  input  1  high while the top FSM is in ADD_EDITS with custom text selected.
- button_enter  input  1  debounced single-cycle enter pulse.
- scan_code  input  8  PS/2 make code, valid when scan_rdy is high.
- scan_rdy  input  1  single-cycle strobe from the keyboard decoder.
- commit_ack  input  1  converter has latched char_array.
- char_array  output  TEXT_LEN_MAX*8  buffer; char k occupies bits [8*(TEXT_LEN_MAX-1-k) +: 8], so char 0 is the MSB byte.
- char_len  output  6  number of characters entered, 0..TEXT_LEN_MAX.
- accepting  output  1  high in ENTRY.
- commit_req  output  1  high in COMMIT.
- text_valid  output  1  high in DONE.
- overflow  output  1  one-cycle pulse when a printable code is dropped because the buffer is full.
- state  output  2  IDLE=0, ENTRY=1, COMMIT=2, DONE=3.

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE; every slot = FILL_CODE; char_len=0.
  - accepting, commit_req, text_valid, overflow all 0.
- All outputs are registered. A buffer write is visible on the clock edge after the scan_rdy cycle.
- Printable set: the 26 letter make codes (1C 32 21 23 24 2B 34 33 43 3B 42 4B 3A 31 44 4D 15 2D 1B 2C 3C 2A 1D 22 35 1A) plus 29 (space).
- IDLE:
  - edit_en=1 -> ENTRY. On the same edge, fill all slots with FILL_CODE and set char_len=0.
  - Otherwise hold the buffer, so text from the last commit is retained.
- ENTRY:
  - Printable code with char_len<TEXT_LEN_MAX: slot[char_len]<=scan_code; char_len+1.
  - Printable code with char_len==TEXT_LEN_MAX: buffer unchanged; overflow pulses for 1 cycle.
  - Code 66 (backspace) with char_len>0: char_len-1; slot[char_len-1]<=FILL_CODE.
  - Code 66 with char_len==0: ignored.
  - Code 5A (enter), or button_enter=1: -> COMMIT. The enter code is never stored.
  - Any other code: ignored, including F0 and E0 prefixes, which the decoder already filters.
  - Printable code or backspace in the same cycle as button_enter: the edit is applied first, then -> COMMIT. The committed buffer includes that edit.
  - edit_en=0 (abort): -> IDLE; buffer reset to FILL_CODE; char_len=0. Abort has priority over scan_rdy and button_enter in that cycle.
- COMMIT:
  - commit_req=1; buffer and char_len frozen; scan_rdy and button_enter ignored.
  - commit_ack sampled high -> DONE; commit_req drops on the same edge.
  - edit_en falling does NOT abort. The handshake always completes, then DONE follows.
  - commit_ack already high on COMMIT entry: DONE after exactly 1 cycle in COMMIT.
- DONE:
  - text_valid=1; buffer frozen; key input ignored.
  - edit_en=0 -> IDLE with the buffer retained. A later edit_en=1 starts a fresh entry.
- commit_ack outside COMMIT is ignored.
- char_len never exceeds TEXT_LEN_MAX and never underflows.

Test Plan:
- Reset, raise edit_en, send scan codes 33,24,4B,4B,44 (HELLO), pulse button_enter -> char_len=5; top 5 bytes = 33 24 4B 4B 44, remaining 15 = 29; commit_req=1; ack 2 cycles later -> state=DONE, text_valid=1, commit_req=0.
- In ENTRY send 1C,32,66,21 -> char_len=2; bytes 0..1 = 1C 21; byte 2 = 29. Send 66 three times from len 2 -> len 0, third backspace ignored, no underflow.
- Send 21 printable codes with TEXT_LEN_MAX=20 -> char_len=20; 21st code dropped; overflow high for exactly 1 cycle; buffer unchanged.
- Same-cycle scan_rdy (code 2C) and button_enter at len 3 -> len 4 with slot3=2C, then COMMIT. Scan code 5A alone -> COMMIT with no byte stored.
- Drop edit_en mid-ENTRY with len 4 -> IDLE, all bytes 29, len 0. Drop edit_en in COMMIT -> commit_req held until ack, then DONE, then IDLE with the buffer retained.
- Assert reset low asynchronously mid-COMMIT, between clock edges -> commit_req=0, state=IDLE, buffer all 29 immediately, without waiting for a clock edge.
